word_splitter: RTL and testbench
================================

Name: word_splitter

Overview:
- Narrowing counterpart of the 16→32 zero-extension path.
- Accepts one 32-bit word through a valid/ready handshake and emits it as two 16-bit halves on a 16-bit valid/ready output.
- Feeds 32-bit datapath values (ALU results, immediates, PC) onto the 16-bit memory/stack bus.
- Registered output; one word in flight; back-to-back words with no bubble.

Parameters:
- HI_FIRST, 0, beat order: 0 = low half first, then high half; 1 = high half first, then low half.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  32  word to split.
- out_valid  output  1  out_data holds a valid half.
- out_ready  input  1  consumer accepts the current half.
- out_data  output  16  current half.
- out_last  output  1  current half is the final beat of its word.
- busy  output  1  a word is held (state != IDLE).

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, out_valid=0, out_data=16'h0000, out_last=0, busy=0, word register cleared.
  - in_ready reads 1 once rst is low.
  - Reset wins over every simultaneous event.
  - A reset mid-word discards the remaining half; no partial beat follows.
- States:
  - IDLE: no word held.
  - BEAT0: first half presented.
  - BEAT1: second half presented.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- in_ready (combinational): (state==IDLE) | (state==BEAT1 & out_ready) | (state==BEAT0 & out_last & out_ready).
  - No combinational path from in_valid to in_ready.
- Transitions:
  - IDLE + accept → BEAT0. Latch the word; out_valid=1 on the next cycle; latency one cycle from accept edge to first beat.
  - BEAT0 + transfer → BEAT1, presenting the second half with out_last=1.
  - BEAT1 + transfer + accept → BEAT0 with the new word. No idle cycle; sustained throughput is 2 beats per word.
  - BEAT1 + transfer, no accept → IDLE; out_valid=0.
  - BEAT0/BEAT1 with out_ready=0 → hold. out_data and out_last stay stable and in_valid is ignored.
- Beat contents:
  - HI_FIRST=0: beat0 = word[15:0], beat1 = word[31:16].
  - HI_FIRST=1: beat0 = word[31:16], beat1 = word[15:0].
- out_last: 0 on BEAT0, 1 on BEAT1, except as modified by the optional feature.
- out_data holds its last value when out_valid=0. Consumers must not sample it then.
- No truncation or sign handling. Bits pass through unmodified; split then concatenate must reproduce the word exactly.

Optional Feature:
- Macro: WORD_SPLITTER_ZERO_HIGH_SKIP_EN.
- Defined: if the accepted word[31:16]==16'h0000, emit a single beat (word[15:0]) with out_last=1 from BEAT0, regardless of HI_FIRST.
  - On that transfer the next state is IDLE, or BEAT0 if a new word is accepted on the same edge.
  - This inverts the zero-extension path in one beat.
- Undefined: every word emits exactly two beats. The zero-detect logic is absent.

Decomposition:
- Shared package/header `word_splitter_pkg` contains:
  - state encoding constants ST_IDLE=2'd0, ST_BEAT0=2'd1, ST_BEAT1=2'd2;
  - WORD_W=32 and HALF_W=16.
- One natural sub-module: `half_select`, a combinational mux that picks the half from (word, beat index, HI_FIRST).
- FSM, word register and handshake logic stay in word_splitter.

Test Plan:
- Single word, HI_FIRST=0, out_ready=1: in_data=32'h1234_ABCD → beats 16'hABCD (last=0) then 16'h1234 (last=1) on consecutive cycles; then busy=0 and in_ready=1.
- HI_FIRST=1, same word → 16'h1234 then 16'hABCD, out_last on the second beat.
- Backpressure: out_ready=0 for 3 cycles during BEAT0 of 32'hDEAD_BEEF → out_data=16'hBEEF stable, in_ready=0, new in_valid ignored; release → 16'hDEAD then idle.
- Back-to-back: in_valid held with 32'h0000_0001, 32'hFFFF_0002 and out_ready=1 → 4 contiguous beats 0001, 0000, 0002, FFFF; in_ready=1 on the BEAT1 cycles.
- Reset mid-word: assert rst during BEAT0 of 32'hCAFE_F00D → next cycle out_valid=0, out_data=0, busy=0; 16'hCAFE never appears.
- With WORD_SPLITTER_ZERO_HIGH_SKIP_EN: 32'h0000_FBFC → single beat 16'hFBFC, out_last=1. 32'h0001_FBFC → two beats; checked without the macro as well (always two beats).

Source files
------------

// File: rtl/word_splitter_pkg.sv
// Shared definitions for the word splitter: FSM state encoding and the
// widths of the wide input word and the narrow output half.
package word_splitter_pkg;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no word held
    ST_BEAT0 = 2'd1,  // first half presented
    ST_BEAT1 = 2'd2   // second half presented
  } state_t;

endpackage

// File: rtl/word_splitter_if.sv
// Handshake bundle for the word splitter.
//   Input side : in_valid/in_ready/in_data (32-bit word)
//   Output side: out_valid/out_ready/out_data (16-bit half) plus out_last
// Modports:
//   slave  - the splitter's view (accepts words, produces halves)
//   master - the environment's view (offers words, consumes halves)
interface word_splitter_if;
  import word_splitter_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [HALF_W-1:0] out_data;
  logic              out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/word_splitter_half_select.sv
// half_select: combinational mux returning one 16-bit half of a 32-bit word.
//   word  - source word
//   beat  - beat index (0 = first beat, 1 = second beat)
//   half  - selected half
// HI_FIRST=0 sends the low half on beat 0; HI_FIRST=1 sends the high half
// on beat 0.
module half_select
  import word_splitter_pkg::*;
#(
  parameter int HI_FIRST = 0
) (
  input  logic [WORD_W-1:0] word,
  input  logic              beat,
  output logic [HALF_W-1:0] half
);

  logic take_high;

  // The high half is taken on beat 1 normally, on beat 0 when order is swapped.
  assign take_high = beat ^ (HI_FIRST != 0);
  assign half      = take_high ? word[WORD_W-1:HALF_W] : word[HALF_W-1:0];

endmodule

// File: rtl/word_splitter.sv
// word_splitter: accepts one 32-bit word over a valid/ready handshake and
// emits it as two 16-bit beats on a registered 16-bit valid/ready output.
// One word is held at a time; a new word may be accepted on the same edge
// the final beat transfers, so words stream back-to-back at 2 beats/word.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (clears state and data registers)
//   bus  - word_splitter_if.slave: in_valid/in_ready/in_data,
//          out_valid/out_ready/out_data/out_last
//   busy - a word is held (state != IDLE)
// Parameter HI_FIRST: 0 = low half first, 1 = high half first.
// Optional macro WORD_SPLITTER_ZERO_HIGH_SKIP_EN: a word whose upper half is
// zero goes out as a single beat (its low half) with out_last=1.
module word_splitter
  import word_splitter_pkg::*;
#(
  parameter int HI_FIRST = 0
) (
  input  logic            clk,
  input  logic            rst,
  word_splitter_if.slave  bus,
  output logic            busy
);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [HALF_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic              in_ready;
  logic              accept;
  logic              xfer;
  logic              load;
  logic              skip;
  logic [HALF_W-1:0] first_half;
  logic [HALF_W-1:0] sel_first;
  logic [HALF_W-1:0] sel_second;

  // First beat comes straight from the incoming word so it can be registered
  // on the accept edge; second beat comes from the held word.
  half_select #(.HI_FIRST(HI_FIRST)) u_sel_first (
    .word (bus.in_data),
    .beat (1'b0),
    .half (sel_first)
  );

  half_select #(.HI_FIRST(HI_FIRST)) u_sel_second (
    .word (word_q),
    .beat (1'b1),
    .half (sel_second)
  );

`ifdef WORD_SPLITTER_ZERO_HIGH_SKIP_EN
  // Zero upper half: a single beat carrying the low half, whatever the order.
  assign skip       = (bus.in_data[WORD_W-1:HALF_W] == '0);
  assign first_half = skip ? bus.in_data[HALF_W-1:0] : sel_first;
`else
  assign skip       = 1'b0;
  assign first_half = sel_first;
`endif

  // in_ready depends only on state and out_ready, never on in_valid.
  // The BEAT0 term only fires for a single-beat word (out_last set in BEAT0).
  assign in_ready = (state_q == ST_IDLE)
                  | ((state_q == ST_BEAT1) & bus.out_ready)
                  | ((state_q == ST_BEAT0) & out_last_q & bus.out_ready);

  assign accept = bus.in_valid & in_ready;
  assign xfer   = (state_q != ST_IDLE) & bus.out_ready;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    load       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) load = 1'b1;
      end
      ST_BEAT0: begin
        if (xfer) begin
          if (out_last_q) begin
            // Single-beat word finished.
            if (accept) begin
              load = 1'b1;
            end else begin
              state_d    = ST_IDLE;
              out_last_d = 1'b0;
            end
          end else begin
            state_d    = ST_BEAT1;
            out_data_d = sel_second;
            out_last_d = 1'b1;
          end
        end
      end
      ST_BEAT1: begin
        if (xfer) begin
          if (accept) begin
            load = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            out_last_d = 1'b0;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        out_last_d = 1'b0;
      end
    endcase

    if (load) begin
      state_d    = ST_BEAT0;
      word_d     = bus.in_data;
      out_data_d = first_half;
      out_last_d = skip;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q != ST_IDLE);
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_word_splitter.sv
// Directed testbench for word_splitter. Two instances share clk/rst:
// dut0 with HI_FIRST=0 and dut1 with HI_FIRST=1. Expected values are
// hand-computed constants; WORD_SPLITTER_ZERO_HIGH_SKIP_EN selects the
// single-beat expectations where the upper half of a word is zero.
module tb_word_splitter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy0, busy1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  word_splitter_if bus0 ();
  word_splitter_if bus1 ();

  word_splitter #(.HI_FIRST(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave), .busy(busy0));
  word_splitter #(.HI_FIRST(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave), .busy(busy1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check one presented beat of dut0.
  task automatic beat0(input string tag, input logic [15:0] d, input logic last);
    chk({tag, ".valid"}, 32'(bus0.out_valid), 32'd1);
    chk({tag, ".data"},  32'(bus0.out_data),  32'(d));
    chk({tag, ".last"},  32'(bus0.out_last),  32'(last));
  endtask

  task automatic idle0(input string tag);
    chk({tag, ".valid"}, 32'(bus0.out_valid), 32'd0);
    chk({tag, ".busy"},  32'(busy0),          32'd0);
    chk({tag, ".ready"}, 32'(bus0.in_ready),  32'd1);
  endtask

  initial begin
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst.valid", 32'(bus0.out_valid), 32'd0);
    chk("rst.data",  32'(bus0.out_data),  32'h0);
    chk("rst.last",  32'(bus0.out_last),  32'd0);
    chk("rst.busy",  32'(busy0),          32'd0);
    rst = 1'b0;
    #1;
    chk("rst.ready", 32'(bus0.in_ready), 32'd1);

    // Single word, low half first
    bus0.in_valid = 1'b1; bus0.in_data = 32'h1234_ABCD; bus0.out_ready = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    beat0("lo.b0", 16'hABCD, 1'b0);
    tick();
    beat0("lo.b1", 16'h1234, 1'b1);
    tick();
    idle0("lo.end");

    // Single word, high half first
    bus1.in_valid = 1'b1; bus1.in_data = 32'h1234_ABCD; bus1.out_ready = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    chk("hi.b0.valid", 32'(bus1.out_valid), 32'd1);
    chk("hi.b0.data",  32'(bus1.out_data),  32'h1234);
    chk("hi.b0.last",  32'(bus1.out_last),  32'd0);
    tick();
    chk("hi.b1.data",  32'(bus1.out_data),  32'hABCD);
    chk("hi.b1.last",  32'(bus1.out_last),  32'd1);
    tick();
    chk("hi.end.valid", 32'(bus1.out_valid), 32'd0);
    chk("hi.end.busy",  32'(busy1),          32'd0);

    // Backpressure during BEAT0
    bus0.in_valid = 1'b1; bus0.in_data = 32'hDEAD_BEEF; bus0.out_ready = 1'b0;
    tick();
    bus0.in_data = 32'h1111_2222;  // offered while stalled, must be ignored
    for (int i = 0; i < 3; i++) begin
      beat0("bp.hold", 16'hBEEF, 1'b0);
      chk("bp.ready", 32'(bus0.in_ready), 32'd0);
      tick();
    end
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
    beat0("bp.hold", 16'hBEEF, 1'b0);
    tick();
    beat0("bp.b1", 16'hDEAD, 1'b1);
    tick();
    idle0("bp.end");

    // Back-to-back words with in_valid held
    bus0.in_valid = 1'b1; bus0.in_data = 32'h0000_0001; bus0.out_ready = 1'b1;
    tick();
    bus0.in_data = 32'hFFFF_0002;
`ifdef WORD_SPLITTER_ZERO_HIGH_SKIP_EN
    beat0("b2b.w0", 16'h0001, 1'b1);
    chk("b2b.ready0", 32'(bus0.in_ready), 32'd1);
    tick();
`else
    beat0("b2b.w0b0", 16'h0001, 1'b0);
    chk("b2b.ready0", 32'(bus0.in_ready), 32'd0);
    tick();
    beat0("b2b.w0b1", 16'h0000, 1'b1);
    chk("b2b.ready1", 32'(bus0.in_ready), 32'd1);
    tick();
`endif
    bus0.in_valid = 1'b0;
    beat0("b2b.w1b0", 16'h0002, 1'b0);
    tick();
    beat0("b2b.w1b1", 16'hFFFF, 1'b1);
    chk("b2b.ready3", 32'(bus0.in_ready), 32'd1);
    tick();
    idle0("b2b.end");

    // Reset in the middle of a word
    bus0.in_valid = 1'b1; bus0.in_data = 32'hCAFE_F00D;
    tick();
    bus0.in_valid = 1'b0;
    beat0("mid.b0", 16'hF00D, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid.valid", 32'(bus0.out_valid), 32'd0);
    chk("mid.data",  32'(bus0.out_data),  32'h0);
    chk("mid.busy",  32'(busy0),          32'd0);
    rst = 1'b0;
    tick();
    chk("mid.after.valid", 32'(bus0.out_valid), 32'd0);
    chk("mid.after.data",  32'(bus0.out_data),  32'h0);

    // Zero upper half
    bus0.in_valid = 1'b1; bus0.in_data = 32'h0000_FBFC;
    tick();
    bus0.in_valid = 1'b0;
`ifdef WORD_SPLITTER_ZERO_HIGH_SKIP_EN
    beat0("zh.b0", 16'hFBFC, 1'b1);
    tick();
`else
    beat0("zh.b0", 16'hFBFC, 1'b0);
    tick();
    beat0("zh.b1", 16'h0000, 1'b1);
    tick();
`endif
    idle0("zh.end");

    // Non-zero upper half: always two beats
    bus0.in_valid = 1'b1; bus0.in_data = 32'h0001_FBFC;
    tick();
    bus0.in_valid = 1'b0;
    beat0("nz.b0", 16'hFBFC, 1'b0);
    tick();
    beat0("nz.b1", 16'h0001, 1'b1);
    tick();
    idle0("nz.end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
